// File: rtl/disp_scan_ctrl.sv
// Scan scheduler for a 4-digit 7-segment display. It sequences the digit-mux
// select and drives the active-low anodes with guard time, blanking and duty control.
module disp_scan_ctrl #(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned GUARD    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] blank_mask,
    input  logic [2:0] bright,
    input  logic [3:0] mux_y,
    output logic [1:0] sel,
    output logic [3:0] an,
    output logic [3:0] digit_q,
    output logic       frame_tick
);

    localparam int unsigned CW   = $clog2(PRESCALE);
    localparam int unsigned ACT  = PRESCALE - GUARD;
    localparam int unsigned STEP = ACT / 8;

    typedef enum logic [1:0] {S_IDLE, S_GUARD, S_ON, S_OFF} state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nx;
    logic [1:0]      r_sel;
    logic [1:0]      w_sel_nx;
    logic [2:0]      r_bright_q;
    logic [3:0]      r_an;
    logic [3:0]      w_an_nx;
    logic [3:0]      r_digit_q;
    logic            r_frame_tick;
    logic            w_ft_nx;
    logic            w_load_digit;
    logic            w_load_bright;
    logic            w_slot_end;
    logic [CW-1:0]   w_on_last;

    assign sel        = r_sel;
    assign an         = r_an;
    assign digit_q    = r_digit_q;
    assign frame_tick = r_frame_tick;

    // Last slot count of the lit window for the brightness latched this slot.
    assign w_on_last  = CW'(GUARD + STEP * (32'(r_bright_q) + 32'd1) - 32'd1);
    assign w_slot_end = (r_cnt == CW'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_sel        <= 2'd0;
            r_bright_q   <= 3'd0;
            r_an         <= 4'hF;
            r_digit_q    <= 4'd0;
            r_frame_tick <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_sel        <= w_sel_nx;
            r_an         <= w_an_nx;
            r_frame_tick <= w_ft_nx;
            if (w_load_bright) r_bright_q <= bright;
            if (w_load_digit)  r_digit_q  <= mux_y;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt + CW'(1);
        w_sel_nx      = r_sel;
        w_load_digit  = 1'b0;
        w_load_bright = 1'b0;
        w_an_nx       = 4'hF;
        w_ft_nx       = 1'b0;

        if (!en) begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
            w_sel_nx   = 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nx = S_GUARD;
                    w_cnt_nx   = '0;
                    w_sel_nx   = 2'd0;
                end
                S_GUARD: begin
                    if (r_cnt == '0) w_load_bright = 1'b1;
                    if (r_cnt == CW'(GUARD - 1)) begin
                        w_load_digit = 1'b1;
                        w_state_nx   = S_ON;
                    end
                end
                S_ON: begin
                    // A full-duty window ends exactly on the slot boundary.
                    if (r_cnt == w_on_last) begin
                        if (w_slot_end) begin
                            w_state_nx = S_GUARD;
                            w_cnt_nx   = '0;
                            w_sel_nx   = r_sel + 2'd1;
                        end else begin
                            w_state_nx = S_OFF;
                        end
                    end
                end
                S_OFF: begin
                    if (w_slot_end) begin
                        w_state_nx = S_GUARD;
                        w_cnt_nx   = '0;
                        w_sel_nx   = r_sel + 2'd1;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                    w_sel_nx   = 2'd0;
                end
            endcase
        end

        // Outputs are registered from the upcoming state so they align with it.
        if (w_state_nx == S_ON && !blank_mask[w_sel_nx])
            w_an_nx = ~(4'b0001 << w_sel_nx);
        w_ft_nx = (w_state_nx == S_ON || w_state_nx == S_OFF) &&
                  (w_cnt_nx == CW'(PRESCALE - 1)) && (w_sel_nx == 2'd3);
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Randomized scoreboard bench for disp_scan_ctrl; expectations come from a
// position-in-slot model of the scan schedule.
module tb_disp_scan_ctrl;

    localparam int unsigned PRESCALE = 18;
    localparam int unsigned GUARD    = 2;
    localparam int unsigned STEP     = (PRESCALE - GUARD) / 8;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] an;
        logic [3:0] dq;
        logic       ft;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [3:0] blank_mask = 4'h0;
    logic [2:0] bright = 3'd7;
    logic [3:0] mux_y;
    logic [1:0] sel;
    logic [3:0] an;
    logic [3:0] digit_q;
    logic       frame_tick;
    logic [3:0] digits [4];

    exp_t q [$];
    int   n_vec = 0;
    int   n_err = 0;

    // model state: active flag, position in slot, digit, latched brightness/nibble
    bit       m_act = 0;
    int       m_pos = 0;
    int       m_dig = 0;
    int       m_bq  = 0;
    logic [3:0] m_dq = 4'd0;

    disp_scan_ctrl #(.PRESCALE(PRESCALE), .GUARD(GUARD)) dut (
        .clk(clk), .rst(rst), .en(en), .blank_mask(blank_mask), .bright(bright),
        .mux_y(mux_y), .sel(sel), .an(an), .digit_q(digit_q), .frame_tick(frame_tick)
    );

    assign mux_y = digits[sel];

    always #5 clk = ~clk;

    // Advance the model by one clock edge using the inputs now applied, push the
    // expected outputs for the following cycle, then let the edge happen.
    task automatic step();
        exp_t e;
        if (rst) begin
            m_act = 0; m_pos = 0; m_dig = 0; m_bq = 0; m_dq = 4'd0;
        end else if (!en) begin
            m_act = 0; m_pos = 0; m_dig = 0;
        end else if (!m_act) begin
            m_act = 1; m_pos = 0; m_dig = 0;
        end else begin
            if (m_pos == 0) m_bq = int'(bright);
            if (m_pos == int'(GUARD) - 1) m_dq = digits[m_dig];
            m_pos++;
            if (m_pos == int'(PRESCALE)) begin
                m_pos = 0;
                m_dig = (m_dig + 1) % 4;
            end
        end
        e.sel = m_act ? 2'(m_dig) : 2'd0;
        e.an  = 4'hF;
        if (m_act && m_pos >= int'(GUARD) && m_pos < int'(GUARD) + int'(STEP) * (m_bq + 1)
            && !blank_mask[m_dig])
            e.an[m_dig] = 1'b0;
        e.dq  = m_dq;
        e.ft  = m_act && (m_pos == int'(PRESCALE) - 1) && (m_dig == 3);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until the model sits at the requested digit/position (bounded).
    task automatic run_to(input int dig, input int pos);
        for (int i = 0; i < 4 * int'(PRESCALE) + 4; i++) begin
            if (m_act && m_dig == dig && m_pos == pos) return;
            step();
        end
        n_err++;
        $display("FAIL run_to: model never reached dig=%0d pos=%0d", dig, pos);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            if ({sel, an, digit_q, frame_tick} !== e || $countones(~an) > 1) begin
                n_err++;
                $display("FAIL vec%0d @%0t: got sel=%0d an=%h dq=%h ft=%b, want sel=%0d an=%h dq=%h ft=%b",
                         n_vec, $time, sel, an, digit_q, frame_tick, e.sel, e.an, e.dq, e.ft);
            end
        end
    end

    initial begin
        digits[0] = 4'd0; digits[1] = 4'd3; digits[2] = 4'd6; digits[3] = 4'd9;

        // reset held with en high
        run(3);
        rst = 1'b0;

        // full brightness, two frames
        run(2 * 4 * PRESCALE);

        // dimmest, then a brightness change in the middle of a slot
        bright = 3'd0;
        run(4 * PRESCALE);
        run_to(1, 8);
        bright = 3'd5;
        run(3 * PRESCALE);

        // blank digit 2 for a frame
        blank_mask = 4'b0100;
        run(4 * PRESCALE);
        blank_mask = 4'b0000;
        bright = 3'd7;

        // drop enable in the lit window of digit 2, then restart
        run_to(2, 5);
        en = 1'b0;
        run(3);
        en = 1'b1;
        run(2 * PRESCALE);

        // reset in the middle of digit 1's slot
        run_to(1, 9);
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(PRESCALE);

        // randomized operation
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 40) == 0) bright = 3'($urandom);
            if ($urandom_range(0, 30) == 0) blank_mask = 4'($urandom);
            if ($urandom_range(0, 60) == 0) digits[$urandom_range(0, 3)] = 4'($urandom);
            if ($urandom_range(0, 150) == 0) en = ~en;
            else if (!en && $urandom_range(0, 5) == 0) en = 1'b1;
            rst = ($urandom_range(0, 400) == 0);
            step();
        end
        rst = 1'b0;
        en = 1'b1;
        run(4);

        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected vectors left unchecked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
